alu_mux_arbiter: RTL and testbench
==================================

Name: alu_mux_arbiter

Overview:
- Round-robin arbiter sharing one ALU operand path, built from the 4:1 mux (a_mux4_1), between four requesters.
- Drives the mux select pair {sel1, sel0} and a one-hot grant vector.
- Holds each grant for a fixed number of cycles so multi-cycle ALU operations complete.
- Sits between requesting units (e.g. address-gen, branch-calc, execute, debug) and the shared mux/ALU.

Parameters:
- HOLD_CYCLES, 4, cycles a grant is held (legal range 1..15).
- CNT_W, 4, hold-counter width (localparam; holds HOLD_CYCLES-1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  request per requester; bit n = requester n; level, held until served
- gnt  output  4  one-hot grant, registered; all zero when idle
- sel0  output  1  mux select LSB = granted index bit 0 (requester n drives input {sel1,sel0}=n: i00=0, i01=1, i10=2, i11=3)
- sel1  output  1  mux select MSB = granted index bit 1
- busy  output  1  high while any grant is active
- last  output  1  high on the final cycle of a full-length grant

Behaviour:
- Reset (async, immediate): gnt=0000, sel0=0, sel1=0, busy=0, last=0, count=0, state=IDLE, ptr=3 (requester 0 highest priority first).
- States:
  - IDLE: no grant.
  - GRANT: gnt one-hot, count runs 0..HOLD_CYCLES-1.
- IDLE: if req!=0 at a rising edge, enter GRANT with the winner. gnt/sel valid the next cycle (1-cycle latency). Otherwise stay in IDLE.
- Winner selection: first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4). On each new grant, ptr := winner.
- GRANT, normal end:
  - count increments each cycle.
  - last = busy && count==HOLD_CYCLES-1 (decoded from registers, no input path).
  - At that edge: if req!=0, grant the next winner immediately (back-to-back, no idle bubble; count restarts at 0). Else go to IDLE.
  - The current holder may be re-granted only if it is the sole requester.
- GRANT, abort: if req[granted] drops before the last cycle, the grant ends at the next edge. last is not asserted. Arbitration proceeds exactly as a normal end, using ptr = the aborted requester.
- Abort and normal end coincide on the last cycle: treated as a normal end.
- HOLD_CYCLES=1: every grant lasts exactly one cycle, and last is high on every busy cycle.
- sel0/sel1 retain their value when entering IDLE (mux output is don't-care). They reset to 00.
- gnt is always one-hot or zero. busy == |gnt.
- Reset asserted mid-grant: all outputs clear asynchronously. After release, arbitration restarts from ptr=3.
- req changes on non-grant bits never disturb the current grant.

Decomposition:
- Package alu_arb_pkg:
  - localparam NREQ=4
  - typedef logic [1:0] req_idx_t
  - typedef enum {IDLE, GRANT} arb_state_t
- Sub-module rr_pick4: combinational (ptr, req) -> (found, winner index).
- Top module owns the state register, hold counter, ptr, and output registers.

Test Plan (HOLD_CYCLES=4):
- Reset release, req=0001 at cycle 0 → gnt=0001, sel={0,0}, busy=1 from cycle 1. last=1 at cycle 4. With req still 0001, re-granted at cycle 5.
- req=1111 held → grants rotate 0001, 0010, 0100, 1000, 0001, each for 4 cycles, back-to-back. sel sequence 00, 01, 10, 11. last on every 4th busy cycle.
- Grant to requester 2, req[2] dropped at count=1 with req=0010 pending → gnt=0010 on the next cycle, no last pulse, count=0.
- req=0100 only, then req=0101 while requester 2 holds → requester 2 keeps gnt for the full 4 cycles, then requester 0 is granted (scan 3, 0).
- Assert reset during count=2 of a grant → gnt=0000, busy=0, sel=00 before the next clock edge. After release with req=1010, requester 1 wins.
- Request drop at count=3 (the last cycle) → treated as normal end: last=1, and the next winner is granted with no bubble.

Source files
------------

// File: rtl/alu_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared types and constants for the ALU operand-mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    // Number of requesters sharing the 4:1 operand mux
    localparam int NREQ = 4;

    // Requester index; doubles as the mux select pair {sel1, sel0}
    typedef logic [1:0] req_idx_t;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // One-hot grant vector for a requester index
    function automatic logic [NREQ-1:0] idx_to_onehot(input req_idx_t idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_mux_arbiter_if
// Description : Request/grant bundle between requesting units and the
//               operand-mux arbiter. The arbiter takes the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_mux_arbiter_if;
    import alu_arb_pkg::*;

    logic [NREQ-1:0] req;   // level request, held until served
    logic [NREQ-1:0] gnt;   // one-hot grant, zero when idle
    logic            sel0;  // mux select LSB
    logic            sel1;  // mux select MSB
    logic            busy;  // any grant active
    logic            last;  // final cycle of a full-length grant

    modport master (
        output req,
        input  gnt, sel0, sel1, busy, last
    );

    modport slave (
        input  req,
        output gnt, sel0, sel1, busy, last
    );

endinterface
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin pick among four requests. Scans
//               ptr+1, ptr+2, ptr+3, ptr (mod 4) and returns the first set
//               request, so the previous winner has the lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import alu_arb_pkg::*;
(
    input  wire req_idx_t         i_ptr,
    input  wire logic [NREQ-1:0]  i_req,
    output logic                  o_found,
    output req_idx_t              o_winner
);

    // Walk the scan order from lowest to highest priority so the
    // highest-priority hit is the one that sticks.
    always_comb begin
        o_found  = 1'b0;
        o_winner = i_ptr;
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[i_ptr + req_idx_t'(k)]) begin
                o_found  = 1'b1;
                o_winner = i_ptr + req_idx_t'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mux_arbiter
// Description : Round-robin arbiter for the shared ALU operand 4:1 mux.
//               Grants one requester at a time for HOLD_CYCLES cycles, drives
//               the mux select pair and a one-hot grant, and re-arbitrates
//               back-to-back at the end of each grant. A holder that drops
//               its request early loses the grant at the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mux_arbiter
    import alu_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 4    // legal range 1..15
)(
    input  wire logic         clk,
    input  wire logic         reset,
    alu_mux_arbiter_if.slave  bus
);

    localparam int               CNT_W      = 4;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(HOLD_CYCLES - 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    req_idx_t         r_ptr;
    req_idx_t         r_sel;
    logic [NREQ-1:0]  r_gnt;
    logic             r_busy;

    logic             w_found;
    req_idx_t         w_winner;
    logic             w_at_last;
    logic             w_grant_end;

    rr_pick4 u_pick (
        .i_ptr    (r_ptr),
        .i_req    (bus.req),
        .o_found  (w_found),
        .o_winner (w_winner)
    );

    // Final hold cycle, or the holder withdrew its request (abort). An abort
    // on the final cycle is indistinguishable from a normal end.
    assign w_at_last   = (r_count == c_last_cnt);
    assign w_grant_end = w_at_last || !bus.req[r_sel];

    // Arbiter FSM: owns state, hold counter, rotation pointer and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_ptr   <= 2'd3;
            r_sel   <= 2'd0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_count <= '0;
                        r_ptr   <= w_winner;
                        r_sel   <= w_winner;
                        r_gnt   <= idx_to_onehot(w_winner);
                        r_busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_grant_end) begin
                        if (w_found) begin
                            // Back-to-back handover, no idle bubble
                            r_count <= '0;
                            r_ptr   <= w_winner;
                            r_sel   <= w_winner;
                            r_gnt   <= idx_to_onehot(w_winner);
                        end else begin
                            // sel keeps its value; mux output is don't-care
                            r_state <= IDLE;
                            r_count <= '0;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.sel0 = r_sel[0];
    assign bus.sel1 = r_sel[1];
    assign bus.busy = r_busy;
    assign bus.last = r_busy && w_at_last;

endmodule
`default_nettype wire

// File: tb/tb_alu_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mux_arbiter
// Description : Self-checking bench for alu_mux_arbiter. Runs a HOLD_CYCLES=4
//               and a HOLD_CYCLES=1 instance side by side on the same
//               requests against a behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mux_arbiter;
    import alu_arb_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_mux_arbiter_if bus0 ();
    alu_mux_arbiter_if bus1 ();

    assign bus0.req = req;
    assign bus1.req = req;

    alu_mux_arbiter #(.HOLD_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    alu_mux_arbiter #(.HOLD_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // ---------------- behavioural model (index 0: hold 4, index 1: hold 1)
    int c_hold   [2] = '{4, 1};
    int m_holder [2];   // -1 when idle
    int m_age    [2];   // cycles already spent in the current grant
    int m_ptr    [2];   // last winner
    int m_sel    [2];   // select last driven

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_holder[d] = -1;
            m_age[d]    = 0;
            m_ptr[d]    = 3;
            m_sel[d]    = 0;
        end
    endfunction

    function automatic void model_step(input int d, input logic [3:0] r);
        int h;
        int idx;
        h = m_holder[d];
        if (h >= 0 && m_age[d] < c_hold[d] - 1 && r[h]) begin
            m_age[d] = m_age[d] + 1;
        end else begin
            m_holder[d] = -1;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_ptr[d] + k) % 4;
                if (r[idx]) begin
                    m_holder[d] = idx;
                    m_ptr[d]    = idx;
                    m_sel[d]    = idx;
                    m_age[d]    = 0;
                    break;
                end
            end
        end
    endfunction

    // Packed {gnt[3:0], sel1, sel0, busy, last}
    function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] s,
                                      input logic b, input logic l);
        return {g, s, b, l};
    endfunction

    function automatic logic [7:0] model_out(input int d);
        logic [3:0] g;
        logic       b;
        g = 4'b0000;
        b = (m_holder[d] >= 0);
        if (b) g[m_holder[d]] = 1'b1;
        return pk(g, 2'(m_sel[d]), b, b && (m_age[d] == c_hold[d] - 1));
    endfunction

    function automatic logic [7:0] dut_out(input int d);
        if (d == 0) return {bus0.gnt, bus0.sel1, bus0.sel0, bus0.busy, bus0.last};
        return {bus1.gnt, bus1.sel1, bus1.sel0, bus1.busy, bus1.last};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got gnt=%b sel=%b busy=%b last=%b, expected gnt=%b sel=%b busy=%b last=%b",
                     name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // One clock: drive req, check outputs, then advance the model at the edge.
    task automatic cycle(input string name, input logic [3:0] r,
                         input logic use_exp, input logic [7:0] exp0);
        @(negedge clk);
        req = r;
        check({name, " h4"}, dut_out(0), use_exp ? exp0 : model_out(0));
        check({name, " h1"}, dut_out(1), model_out(1));
        @(posedge clk);
        model_step(0, r);
        model_step(1, r);
    endtask

    task automatic hstep(input string name, input logic [3:0] r, input logic [3:0] g,
                         input logic [1:0] s, input logic b, input logic l);
        cycle(name, r, 1'b1, pk(g, s, b, l));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        check("reset_state h4", dut_out(0), 8'h00);
        check("reset_state h1", dut_out(1), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [7:0] exp;
    } vec_t;

    vec_t tv[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        logic [3:0] cur;

        // Table: single requester re-grant, then full rotation under 1111
        tv.push_back('{4'b0001, pk(4'b0000, 2'b00, 1'b0, 1'b0)});
        tv.push_back('{4'b0001, pk(4'b0001, 2'b00, 1'b1, 1'b0)});
        tv.push_back('{4'b0001, pk(4'b0001, 2'b00, 1'b1, 1'b0)});
        tv.push_back('{4'b0001, pk(4'b0001, 2'b00, 1'b1, 1'b0)});
        tv.push_back('{4'b0001, pk(4'b0001, 2'b00, 1'b1, 1'b1)});
        for (int n = 0; n < 5; n++) begin
            g = 4'b0001 << (n % 4);
            for (int c = 0; c < 4; c++)
                tv.push_back('{4'b1111, pk(g, 2'(n % 4), 1'b1, c == 3)});
        end

        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        foreach (tv[i])
            cycle($sformatf("table[%0d]", i), tv[i].req, 1'b1, tv[i].exp);

        // Abort at count=1 with requester 1 pending
        do_reset();
        hstep("abort idle",   4'b0100, 4'b0000, 2'b00, 1'b0, 1'b0);
        hstep("abort c0",     4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0);
        hstep("abort c1",     4'b0010, 4'b0100, 2'b10, 1'b1, 1'b0);
        hstep("abort next",   4'b0010, 4'b0010, 2'b01, 1'b1, 1'b0);
        hstep("abort next1",  4'b0010, 4'b0010, 2'b01, 1'b1, 1'b0);

        // Non-grant request arriving mid-grant does not disturb holder
        do_reset();
        hstep("hold idle",    4'b0100, 4'b0000, 2'b00, 1'b0, 1'b0);
        hstep("hold c0",      4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0);
        hstep("hold c1",      4'b0101, 4'b0100, 2'b10, 1'b1, 1'b0);
        hstep("hold c2",      4'b0101, 4'b0100, 2'b10, 1'b1, 1'b0);
        hstep("hold c3",      4'b0101, 4'b0100, 2'b10, 1'b1, 1'b1);
        hstep("hold next",    4'b0000, 4'b0001, 2'b00, 1'b1, 1'b0);
        hstep("hold idle2",   4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

        // Drop on the last cycle is a normal end; sel retained in idle
        do_reset();
        hstep("lastdrop idle", 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0);
        hstep("lastdrop c0",   4'b1000, 4'b1000, 2'b11, 1'b1, 1'b0);
        hstep("lastdrop c1",   4'b1000, 4'b1000, 2'b11, 1'b1, 1'b0);
        hstep("lastdrop c2",   4'b1000, 4'b1000, 2'b11, 1'b1, 1'b0);
        hstep("lastdrop c3",   4'b0010, 4'b1000, 2'b11, 1'b1, 1'b1);
        hstep("lastdrop next", 4'b0000, 4'b0010, 2'b01, 1'b1, 1'b0);
        hstep("sel retain",    4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0);

        // Asynchronous reset during count=2
        do_reset();
        hstep("rstmid idle", 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0);
        hstep("rstmid c0",   4'b1000, 4'b1000, 2'b11, 1'b1, 1'b0);
        hstep("rstmid c1",   4'b1000, 4'b1000, 2'b11, 1'b1, 1'b0);
        @(negedge clk);
        check("rstmid c2 h4", dut_out(0), pk(4'b1000, 2'b11, 1'b1, 1'b0));
        #1;
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        check("rstmid async h4", dut_out(0), 8'h00);
        check("rstmid async h1", dut_out(1), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        hstep("rstmid after idle", 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0);
        hstep("rstmid winner",     4'b1010, 4'b0010, 2'b01, 1'b1, 1'b0);

        // Randomised level requests against the model
        do_reset();
        cur = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) begin
                do_reset();
                cur = 4'b0000;
            end
            case ($urandom_range(0, 19))
                0:       cur = 4'b0000;
                1:       cur = 4'b1111;
                default: begin
                    for (int b = 0; b < 4; b++)
                        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
                end
            endcase
            cycle("random", cur, 1'b0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
